// File: rtl/skeletonize_multi.sv
// -----------------------------------------------------------------------------
// skeletonize_multi
//
// Finds the longest bright run in each video line of an fvh-framed pixel
// stream and reports its fixed-point midpoint, length and row once per line.
// Short dark gaps (fewer than GAP_TOL pixels) are absorbed into a run.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   fvh_in[2:0]  [1] field/frame flag, [0] line flag, [2] unused
//   dv_in        pixel valid
//   px_in        pixel value, bright iff px_in >= THRESH
//   current_row  row index of the reported line
//   midpoint     centre column of the longest run, FRAC_BITS fractional bits
//   run_length   length of the reported run (0 when none found)
//   found        a run of at least MIN_RUN existed in the line
//   row_done     one-cycle pulse, outputs are valid while it is high
//   first_row    high until the first line of a frame has been reported
// -----------------------------------------------------------------------------
module skeletonize_multi #(
   parameter int               PIX_W     = 8,
   parameter int               COL_W     = 10,
   parameter int               ROW_W     = 10,
   parameter logic [PIX_W-1:0] THRESH    = 8'h80,
   parameter int               GAP_TOL   = 3,
   parameter int               MIN_RUN   = 2,
   parameter int               FRAC_BITS = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2:0]                 fvh_in,
   input  logic                       dv_in,
   input  logic [PIX_W-1:0]           px_in,
   output logic [ROW_W-1:0]           current_row,
   output logic [COL_W+FRAC_BITS-1:0] midpoint,
   output logic [COL_W:0]             run_length,
   output logic                       found,
   output logic                       row_done,
   output logic                       first_row
);

   localparam int MID_W = COL_W + FRAC_BITS;
   localparam int LEN_W = COL_W + 1;
   localparam int SHIFT = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_RUN);
   localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
   localparam logic [LEN_W:0]   ONE_S   = (LEN_W+1)'(1);
   localparam logic [4:0]       GAP_LIM = 5'(GAP_TOL);

   typedef enum logic [1:0] {S_DARK, S_RUN, S_GAP} state_t;

   function automatic logic [LEN_W-1:0] run_len(input logic [COL_W-1:0] s,
                                                input logic [COL_W-1:0] e);
      return {1'b0, e} - {1'b0, s} + ONE_L;
   endfunction

   // Strict '>' keeps the earliest of equally long runs.
   function automatic logic beats(input logic [LEN_W-1:0] len,
                                  input logic [LEN_W-1:0] best);
      return (len >= MIN_LEN) && (len > best);
   endfunction

   // start+end is already the midpoint with one fractional bit; more
   // fractional bits are exact left shifts, zero bits rounds half up.
   function automatic logic [MID_W-1:0] mid_calc(input logic [COL_W-1:0] s,
                                                 input logic [COL_W-1:0] e);
      logic [LEN_W:0] sum;
      sum = {2'b00, s} + {2'b00, e};
      if (FRAC_BITS == 0) return MID_W'((sum + ONE_S) >> 1);
      else                return MID_W'(sum) << SHIFT;
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          last_fvh_q, last_fvh_d;
   logic [COL_W:0]      col_q, col_d;
   logic [COL_W-1:0]    start_q, start_d, end_q, end_d;
   logic [3:0]          gap_q, gap_d;
   logic [LEN_W-1:0]    best_len_q, best_len_d;
   logic [COL_W-1:0]    best_start_q, best_start_d, best_end_q, best_end_d;
   logic [ROW_W-1:0]    current_row_q, current_row_d;
   logic [MID_W-1:0]    midpoint_q, midpoint_d;
   logic [LEN_W-1:0]    run_length_q, run_length_d;
   logic                found_q, found_d;
   logic                row_done_q, row_done_d;
   logic                first_row_q, first_row_d;

   logic                new_frame, new_line, pix_ok, bright, close_run;
   logic [COL_W-1:0]    cur_col;
   logic [LEN_W-1:0]    open_len, fin_len;
   logic [COL_W-1:0]    fin_start, fin_end;

   always_comb begin
      state_d       = state_q;
      last_fvh_d    = fvh_in;
      col_d         = col_q;
      start_d       = start_q;
      end_d         = end_q;
      gap_d         = gap_q;
      best_len_d    = best_len_q;
      best_start_d  = best_start_q;
      best_end_d    = best_end_q;
      current_row_d = current_row_q;
      midpoint_d    = midpoint_q;
      run_length_d  = run_length_q;
      found_d       = found_q;
      row_done_d    = 1'b0;
      first_row_d   = first_row_q;
      close_run     = 1'b0;

      new_frame = fvh_in[1] & ~last_fvh_q[1];
      new_line  = last_fvh_q[0] & ~fvh_in[0];
      // col_q[COL_W] set means the last column was already consumed.
      pix_ok    = dv_in & ~col_q[COL_W];
      bright    = (px_in >= THRESH);
      cur_col   = col_q[COL_W-1:0];
      open_len  = run_len(start_q, end_q);

      // A run still open at line end competes with the best closed run.
      fin_len   = best_len_q;
      fin_start = best_start_q;
      fin_end   = best_end_q;
      if ((state_q != S_DARK) && beats(open_len, best_len_q)) begin
         fin_len   = open_len;
         fin_start = start_q;
         fin_end   = end_q;
      end

      if (new_frame || new_line) begin
         if (new_frame) begin
            first_row_d = 1'b1;
         end else begin
            row_done_d    = 1'b1;
            current_row_d = first_row_q ? '0 : current_row_q + 1'b1;
            first_row_d   = 1'b0;
            run_length_d  = fin_len;
            found_d       = (fin_len != '0);
            midpoint_d    = (fin_len != '0) ? mid_calc(fin_start, fin_end) : '0;
         end
         state_d      = S_DARK;
         col_d        = '0;
         start_d      = '0;
         end_d        = '0;
         gap_d        = '0;
         best_len_d   = '0;
         best_start_d = '0;
         best_end_d   = '0;
      end else if (pix_ok) begin
         col_d = col_q + 1'b1;
         unique case (state_q)
            S_DARK: begin
               if (bright) begin
                  state_d = S_RUN;
                  start_d = cur_col;
                  end_d   = cur_col;
               end
            end
            S_RUN: begin
               if (bright) begin
                  end_d = cur_col;
               end else if (GAP_LIM == 5'd1) begin
                  close_run = 1'b1;
                  state_d   = S_DARK;
               end else begin
                  state_d = S_GAP;
                  gap_d   = 4'd1;
               end
            end
            S_GAP: begin
               if (bright) begin
                  state_d = S_RUN;
                  end_d   = cur_col;
                  gap_d   = '0;
               end else if (({1'b0, gap_q} + 5'd1) == GAP_LIM) begin
                  close_run = 1'b1;
                  state_d   = S_DARK;
                  gap_d     = '0;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            default: state_d = S_DARK;
         endcase
         if (close_run && beats(open_len, best_len_q)) begin
            best_len_d   = open_len;
            best_start_d = start_q;
            best_end_d   = end_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_DARK;
         last_fvh_q    <= '0;
         col_q         <= '0;
         start_q       <= '0;
         end_q         <= '0;
         gap_q         <= '0;
         best_len_q    <= '0;
         best_start_q  <= '0;
         best_end_q    <= '0;
         current_row_q <= '0;
         midpoint_q    <= '0;
         run_length_q  <= '0;
         found_q       <= 1'b0;
         row_done_q    <= 1'b0;
         first_row_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         last_fvh_q    <= last_fvh_d;
         col_q         <= col_d;
         start_q       <= start_d;
         end_q         <= end_d;
         gap_q         <= gap_d;
         best_len_q    <= best_len_d;
         best_start_q  <= best_start_d;
         best_end_q    <= best_end_d;
         current_row_q <= current_row_d;
         midpoint_q    <= midpoint_d;
         run_length_q  <= run_length_d;
         found_q       <= found_d;
         row_done_q    <= row_done_d;
         first_row_q   <= first_row_d;
      end
   end

   assign current_row = current_row_q;
   assign midpoint    = midpoint_q;
   assign run_length  = run_length_q;
   assign found       = found_q;
   assign row_done    = row_done_q;
   assign first_row   = first_row_q;

endmodule

// File: tb/tb_skeletonize_multi.sv
// Directed bench for skeletonize_multi with a scoreboard of expected lines.
module tb_skeletonize_multi;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  fvh;
   logic        dv;
   logic [7:0]  px;
   logic [9:0]  current_row;
   logic [10:0] midpoint;
   logic [10:0] run_length;
   logic        found;
   logic        row_done;
   logic        first_row;

   skeletonize_multi dut (
      .clk         (clk),
      .reset       (reset),
      .fvh_in      (fvh),
      .dv_in       (dv),
      .px_in       (px),
      .current_row (current_row),
      .midpoint    (midpoint),
      .run_length  (run_length),
      .found       (found),
      .row_done    (row_done),
      .first_row   (first_row)
   );

   typedef struct {
      int row;
      int mid;
      int len;
      int fnd;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] line_px [1024];
   logic       fvh1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every row_done pulse is matched against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (row_done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row_done: got pulse for row %0d, expected none",
                     current_row);
         end else begin
            e = sb.pop_front();
            chk("current_row", int'(current_row), e.row);
            chk("midpoint",    int'(midpoint),    e.mid);
            chk("run_length",  int'(run_length),  e.len);
            chk("found",       int'(found),       e.fnd);
            chk("first_row",   int'(first_row),   0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_px(input logic [7:0] v);
      for (int i = 0; i < 1024; i++) line_px[i] = v;
   endtask

   task automatic set_bright(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) line_px[i] = 8'hFF;
   endtask

   task automatic expect_row(input int row, input int mid, input int len, input int fnd);
      exp_t e;
      e.row = row; e.mid = mid; e.len = len; e.fnd = fnd;
      sb.push_back(e);
   endtask

   // dv=0 cycles inserted by 'toggle' carry a bright value that must be ignored.
   task automatic send_line(input int npix, input bit toggle, input bit end_line);
      for (int c = 0; c < npix; c++) begin
         fvh = {1'b0, fvh1, 1'b1}; dv = 1'b1; px = line_px[c];
         tick();
         if (toggle) begin
            dv = 1'b0; px = 8'hFF;
            tick();
         end
      end
      dv = 1'b0; px = 8'h00;
      if (end_line) begin
         fvh = {1'b0, fvh1, 1'b0};
         repeat (4) tick();
      end
   endtask

   task automatic idle(input int n);
      fvh = {1'b0, fvh1, 1'b0}; dv = 1'b0; px = 8'h00;
      repeat (n) tick();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_current_row"}, int'(current_row), 0);
      chk({tag, "_midpoint"},    int'(midpoint),    0);
      chk({tag, "_run_length"},  int'(run_length),  0);
      chk({tag, "_found"},       int'(found),       0);
      chk({tag, "_row_done"},    int'(row_done),    0);
      chk({tag, "_first_row"},   int'(first_row),   1);
   endtask

   initial begin
      reset = 1'b1; fvh = 3'b000; dv = 1'b0; px = 8'h00; fvh1 = 1'b0;
      repeat (3) tick();
      check_reset_state("reset");
      reset = 1'b0;
      fvh1 = 1'b1;
      idle(3);

      // Frame A: function vectors
      clear_px(8'h00); set_bright(100, 109);
      expect_row(0, 209, 10, 1); send_line(256, 0, 1);

      clear_px(8'h00); set_bright(50, 59); set_bright(62, 65);
      expect_row(1, 115, 16, 1); send_line(256, 0, 1);

      clear_px(8'h00); set_bright(50, 59); set_bright(63, 70);
      expect_row(2, 109, 10, 1); send_line(256, 0, 1);

      clear_px(8'h00); set_bright(10, 14); set_bright(200, 204);
      expect_row(3, 24, 5, 1); send_line(256, 0, 1);

      clear_px(8'h00);
      line_px[5] = 8'hFF; line_px[20] = 8'hFF; line_px[40] = 8'hFF; line_px[60] = 8'hFF;
      expect_row(4, 0, 0, 0); send_line(256, 0, 1);

      clear_px(8'h00); set_bright(1014, 1023);
      expect_row(5, 2037, 10, 1); send_line(1024, 0, 1);

      clear_px(8'h7F);
      expect_row(6, 0, 0, 0); send_line(256, 0, 1);

      clear_px(8'h00); set_bright(20, 29);
      expect_row(7, 49, 10, 1); send_line(64, 1, 1);

      // Frame B: three lines, then a line cut by a new frame
      fvh1 = 1'b0; idle(2);
      fvh1 = 1'b1; idle(2);
      clear_px(8'h00); set_bright(100, 109);
      expect_row(0, 209, 10, 1); send_line(128, 0, 1);
      clear_px(8'h00); set_bright(300, 303);
      expect_row(1, 603, 4, 1); send_line(400, 0, 1);
      clear_px(8'h00); set_bright(0, 1);
      expect_row(2, 1, 2, 1); send_line(64, 0, 1);

      fvh1 = 1'b0; idle(2);
      clear_px(8'h00); set_bright(10, 19);
      send_line(60, 0, 0);
      fvh1 = 1'b1;
      fvh = 3'b010;
      tick();
      idle(4);
      chk("cut_first_row",  int'(first_row),  1);
      chk("cut_hold_len",   int'(run_length), 2);
      chk("cut_hold_mid",   int'(midpoint),   1);
      chk("cut_hold_row",   int'(current_row), 2);

      // Frame C: two lines after the cut
      clear_px(8'h00); set_bright(500, 504);
      expect_row(0, 1004, 5, 1); send_line(600, 0, 1);
      clear_px(8'h00); set_bright(700, 711);
      expect_row(1, 1411, 12, 1); send_line(800, 0, 1);

      // Reset in the middle of a line
      clear_px(8'h00); set_bright(5, 20);
      send_line(30, 0, 0);
      reset = 1'b1; fvh = 3'b000; dv = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      check_reset_state("midline_reset");

      repeat (5) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_row_done: got %0d lines unreported, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
